// File: rtl/rr_pkg.sv
// Shared round-robin constants and helpers, common to the dispatcher and the arbiter.
package rr_pkg;

   localparam int RR_DEFAULT_N      = 4;
   localparam int RR_DEFAULT_DATA_W = 32;

   // Pointer width for n channels; never below one bit.
   function automatic int rr_ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority pick: lowest requester at or after ptr, otherwise lowest requester overall.
module rr_pick
   import rr_pkg::*;
#(
   parameter int N  = RR_DEFAULT_N,
   parameter int PW = rr_ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   logic [N-1:0] masked_s;
   logic [N-1:0] sel_s;
   logic         found_s;

   // Masked-then-unmasked lowest-set-bit scan.
   always_comb begin
      masked_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         masked_s[i] = req[i] && (PW'(i) >= ptr);
      end
      sel_s   = (|masked_s) ? masked_s : req;
      idx     = {PW{1'b0}};
      grant   = {N{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel_s[i] && !found_s) begin
            idx      = PW'(i);
            grant[i] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin 1-to-N stream dispatcher with one output register per channel.
// Optional feature macro: RR_DISPATCH_SKIP_BUSY_EN (skip busy channels instead of strict rotation).
module rr_dispatcher
   import rr_pkg::*;
#(
   parameter int N      = RR_DEFAULT_N,
   parameter int DATA_W = RR_DEFAULT_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output logic [N*DATA_W-1:0]   out_data,
   output logic [$clog2(N)-1:0]  last_ch
);

   localparam int PW = rr_ptr_w(N);

   logic [N-1:0]  free_s;
   logic [N-1:0]  elig_s;
   logic [N-1:0]  grant_s;
   logic [PW-1:0] idx_s;
   logic [PW-1:0] ptr_r;
   logic          any_s;
   logic          xfer_s;

   // A channel is free when empty or draining this cycle; eligibility depends on the rotation mode.
   always_comb begin
      free_s = ~out_valid | out_ready;
`ifdef RR_DISPATCH_SKIP_BUSY_EN
      elig_s = free_s;
`else
      elig_s = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         elig_s[i] = free_s[i] && (ptr_r == PW'(i));
      end
`endif
   end

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req   (elig_s),
      .ptr   (ptr_r),
      .grant (grant_s),
      .idx   (idx_s),
      .any   (any_s)
   );

   // Held low throughout reset even though the empty slots would otherwise look free.
   assign in_ready = rst_n & any_s;
   assign xfer_s   = in_valid & in_ready;

   // Slot registers, rotation pointer and last-target register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= {N{1'b0}};
         out_data  <= {(N*DATA_W){1'b0}};
         ptr_r     <= {PW{1'b0}};
         last_ch   <= {PW{1'b0}};
      end else begin
         for (int i = 0; i < N; i++) begin
            if (xfer_s && grant_s[i]) begin
               out_valid[i]                    <= 1'b1;
               out_data[i*DATA_W +: DATA_W]    <= in_data;
            end else if (out_ready[i]) begin
               out_valid[i]                    <= 1'b0;
            end else begin
               out_valid[i]                    <= out_valid[i];
            end
         end
         if (xfer_s) begin
            // Wrap by compare so non-power-of-two N never reaches an invalid index.
            ptr_r   <= (idx_s == PW'(N - 1)) ? {PW{1'b0}} : idx_s + PW'(1);
            last_ch <= idx_s;
         end else begin
            ptr_r   <= ptr_r;
            last_ch <= last_ch;
         end
      end
   end

endmodule
